// File: rtl/aoi7458_bist_ctrl.sv
`timescale 1ns/1ps
// BIST sequencer for the dual AND-OR gate block: sweeps all 1024 input vectors,
// compares both outputs against a golden model and records error count and first failure.
module aoi7458_bist_ctrl #(
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_CNT_W     = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [5:0]           dut_p1,
   output logic [3:0]           dut_p2,
   input  logic                 dut_p1y,
   input  logic                 dut_p2y,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 first_err_valid,
   output logic [9:0]           first_err_vec
);

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

   localparam logic [3:0]           WAIT_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;
   localparam logic [9:0]           VEC_LAST  = 10'd1023;

   state_t     state;
   logic [9:0] vec;
   logic [3:0] wait_cnt;
   logic       g1, g2, mismatch;

   assign g1       = (vec[0] & vec[1] & vec[2]) | (vec[3] & vec[4] & vec[5]);
   assign g2       = (vec[6] & vec[7]) | (vec[8] & vec[9]);
   assign mismatch = (dut_p1y != g1) | (dut_p2y != g2);

   // Gate inputs are forced low whenever no sweep is in progress.
   assign dut_p1 = busy ? vec[5:0] : 6'd0;
   assign dut_p2 = busy ? vec[9:6] : 4'd0;
   assign pass   = done && (err_count == '0);

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         vec             <= '0;
         wait_cnt        <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_vec   <= '0;
      end else if (abort) begin
         // Results survive an abort so the host can still read them.
         state    <= IDLE;
         vec      <= '0;
         wait_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state           <= APPLY;
                  vec             <= '0;
                  wait_cnt        <= '0;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  err_count       <= '0;
                  first_err_valid <= 1'b0;
                  first_err_vec   <= '0;
               end
            end
            APPLY: begin
               wait_cnt <= wait_cnt + 4'd1;
               if (wait_cnt == WAIT_LAST) state <= CHECK;
            end
            CHECK: begin
               if (mismatch) begin
                  if (err_count != ERR_MAX) err_count <= err_count + ERR_CNT_W'(1);
                  if (!first_err_valid) begin
                     first_err_valid <= 1'b1;
                     first_err_vec   <= vec;
                  end
               end
               if (vec == VEC_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  vec      <= vec + 10'd1;
                  wait_cnt <= '0;
                  state    <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aoi7458_bist_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench: a cycle-count based reference of the sweep is compared
// every cycle, plus hand-computed end-of-run results for fixed fault patterns.
module tb_aoi7458_bist_ctrl;

   localparam int S      = 1;
   localparam int S8     = 3;
   localparam int ERRMAX = 2047;

   logic clk = 1'b0;
   logic rst_n, start, abort, start8;
   logic [5:0]  p1, p1_8;
   logic [3:0]  p2, p2_8;
   logic        p1y, p2y, p1y_8, p2y_8;
   logic        busy, done, pass, busy8, done8, pass8;
   logic [10:0] errc;
   logic [7:0]  err8;
   logic        fev, fev8;
   logic [9:0]  fvec, fvec8;

   int             mode;   // 0 good, 1 p1y stuck-0, 2 p2y stuck-1, 3 random flips on p1y
   logic [1023:0]  flip;
   int             n_checks = 0;
   int             n_fail   = 0;
   int             cyc_no   = 0;
   int             t0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_no++;

   aoi7458_bist_ctrl #(.SETTLE_CYCLES(S), .ERR_CNT_W(11)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dut_p1(p1), .dut_p2(p2), .dut_p1y(p1y), .dut_p2y(p2y),
      .busy(busy), .done(done), .pass(pass), .err_count(errc),
      .first_err_valid(fev), .first_err_vec(fvec)
   );

   aoi7458_bist_ctrl #(.SETTLE_CYCLES(S8), .ERR_CNT_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .abort(1'b0),
      .dut_p1(p1_8), .dut_p2(p2_8), .dut_p1y(p1y_8), .dut_p2y(p2y_8),
      .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
      .first_err_valid(fev8), .first_err_vec(fvec8)
   );

   function automatic bit gold1(input int v);
      return ((v & 7) == 7) || (((v >> 3) & 7) == 7);
   endfunction
   function automatic bit gold2(input int v);
      return (((v >> 6) & 3) == 3) || (((v >> 8) & 3) == 3);
   endfunction
   function automatic bit resp1(input int md, input logic [1023:0] fl, input int v);
      if (md == 1) return 1'b0;
      if (md == 3) return gold1(v) ^ fl[v];
      return gold1(v);
   endfunction
   function automatic bit resp2(input int md, input int v);
      if (md == 2) return 1'b1;
      return gold2(v);
   endfunction
   function automatic bit mis(input int v);
      return (resp1(mode, flip, v) != gold1(v)) || (resp2(mode, v) != gold2(v));
   endfunction

   // Gate-block stand-ins driven from the sequencer's own pins.
   assign p1y   = resp1(mode, flip, int'({p2, p1}));
   assign p2y   = resp2(mode, int'({p2, p1}));
   assign p1y_8 = gold1(int'({p2_8, p1_8}));
   assign p2y_8 = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a run is just a count of clocks since the start edge; vector v
   // occupies clocks v*(S+1) .. v*(S+1)+S and is judged on its last clock.
   bit m_active, m_done, m_fv;
   int m_cyc, m_err, m_fvec;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_done = 0; m_fv = 0; m_cyc = 0; m_err = 0; m_fvec = 0;
      end else if (abort) begin
         m_active = 0; m_done = 0; m_cyc = 0;
      end else if (start && !m_active) begin
         m_active = 1; m_done = 0; m_cyc = 0; m_err = 0; m_fv = 0; m_fvec = 0;
      end else if (m_active) begin
         if (m_cyc % (S + 1) == S) begin
            int v;
            v = m_cyc / (S + 1);
            if (mis(v)) begin
               if (m_err < ERRMAX) m_err++;
               if (!m_fv) begin m_fv = 1; m_fvec = v; end
            end
            if (v == 1023) begin m_active = 0; m_done = 1; end
         end
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      int ev;
      ev = m_active ? m_cyc / (S + 1) : 0;
      check("busy", 32'(busy), 32'(m_active));
      check("dut_p1", 32'(p1), 32'(ev % 64));
      check("dut_p2", 32'(p2), 32'(ev / 64));
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_done && m_err == 0));
      check("err_count", 32'(errc), 32'(m_err));
      check("first_err_valid", 32'(fev), 32'(m_fv));
      check("first_err_vec", 32'(fvec), 32'(m_fvec));
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      t0 = cyc_no;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 5000) begin tick(1); n++; end
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_latency"}, 32'(cyc_no - t0), 32'd2048);
   endtask

   task automatic random_flips();
      for (int i = 0; i < 1024; i++) flip[i] = ($urandom_range(7) == 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; start8 = 1'b0;
      mode = 0; flip = '0;
      tick(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_p1", 32'(p1), 32'd0);
      check("rst_err", 32'(errc), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // T1: good gate block
      pulse_start();
      wait_done("t1");
      check("t1_pass", 32'(pass), 32'd1);
      check("t1_err", 32'(errc), 32'd0);
      check("t1_fev", 32'(fev), 32'd0);
      tick(3);

      // T2: p1y stuck-at-0
      mode = 1;
      pulse_start();
      wait_done("t2");
      check("t2_err", 32'(errc), 32'd240);
      check("t2_fvec", 32'(fvec), 32'h007);
      check("t2_pass", 32'(pass), 32'd0);
      tick(3);

      // T3: p2y stuck-at-1
      mode = 2;
      pulse_start();
      wait_done("t3");
      check("t3_err", 32'(errc), 32'd576);
      check("t3_fvec", 32'(fvec), 32'h000);
      tick(3);

      // T6a: random fault map, extra start pulse mid-run must be ignored
      mode = 3;
      random_flips();
      pulse_start();
      tick($urandom_range(1500, 100));
      start = 1'b1; tick(1); start = 1'b0;
      wait_done("t6a");
      tick(3);

      // T5: abort at vec 100, results retained, then a clean rerun
      random_flips();
      pulse_start();
      tick(200);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_p1", 32'(p1), 32'd0);
      check("t5_p2", 32'(p2), 32'd0);
      tick(4);
      pulse_start();
      wait_done("t5_rerun");
      tick(2);

      // T6c: start and abort together in IDLE
      abort = 1'b1; tick(1); abort = 1'b0; tick(1);
      start = 1'b1; abort = 1'b1; tick(1);
      start = 1'b0; abort = 1'b0; tick(2);
      check("t6c_busy", 32'(busy), 32'd0);
      check("t6c_done", 32'(done), 32'd0);

      // T6b: asynchronous reset mid-run
      random_flips();
      pulse_start();
      tick($urandom_range(900, 300));
      rst_n = 1'b0;
      #1;
      check("t6b_busy", 32'(busy), 32'd0);
      check("t6b_p1", 32'(p1), 32'd0);
      check("t6b_p2", 32'(p2), 32'd0);
      check("t6b_err", 32'(errc), 32'd0);
      check("t6b_fev", 32'(fev), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // T4: 8-bit counter saturates with p2y stuck-at-1, settle 3 cycles
      start8 = 1'b1; tick(1); start8 = 1'b0;
      t0 = cyc_no;
      begin
         int n = 0;
         while (!done8 && n < 6000) begin tick(1); n++; end
      end
      check("t4_done", 32'(done8), 32'd1);
      check("t4_latency", 32'(cyc_no - t0), 32'd4096);
      check("t4_err", 32'(err8), 32'd255);
      check("t4_pass", 32'(pass8), 32'd0);
      check("t4_fev", 32'(fev8), 32'd1);
      check("t4_fvec", 32'(fvec8), 32'd0);

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
